// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
// Geometry shared by everything that touches the 128x64 1bpp SSD1306
// framebuffer (the SPI writer on one side, the video scanout on the other).
// The framebuffer is page-organised: one byte covers 8 vertical pixels of a
// column, and its address is {page[2:0], column[6:0]}.
// -----------------------------------------------------------------------------
package oled_pkg;

  localparam int OLED_WIDTH  = 128;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PAGES  = 8;
  localparam int FB_ADDR_W   = 10;
  localparam int PAGE_W      = 3;
  localparam int COL_W       = 7;
  localparam int ROW_W       = 6;
  localparam int BIT_W       = 3;

  typedef logic [PAGE_W-1:0]    page_t;
  typedef logic [COL_W-1:0]     col_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  // Per-pixel side-band that travels with the read address through the pipe.
  typedef struct packed {
    logic             active;
    logic             hs;
    logic             vs;
    logic [BIT_W-1:0] bit_idx;
  } scan_tag_t;

  function automatic fb_addr_t fb_addr(input page_t page, input col_t col);
    return {page, col};
  endfunction

endpackage

// File: rtl/oled_video_timing.sv
// -----------------------------------------------------------------------------
// oled_video_timing
// Raster counters for the scaled OLED image. Active area comes first in every
// line and frame, blanking follows. Pixel coordinates are tracked with
// sub-pixel counters so no divide/multiply is needed.
// Ports: clk_i, rst_ni (async active-low)
//        active_o       h/v inside the active area
//        hs_o / vs_o    sync strobes (undelayed)
//        frame_start_o  h_cnt == 0 and v_cnt == 0
//        x_pix_o/y_pix_o OLED pixel coordinate of the current clock
// -----------------------------------------------------------------------------
module oled_video_timing
  import oled_pkg::*;
#(
  parameter int SCALE   = 3,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 8,
  parameter int H_BACK  = 32,
  parameter int V_FRONT = 4,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             active_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             frame_start_o,
  output logic [COL_W-1:0] x_pix_o,
  output logic [ROW_W-1:0] y_pix_o
);

  localparam int H_ACTIVE = OLED_WIDTH * SCALE;
  localparam int V_ACTIVE = OLED_HEIGHT * SCALE;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACTEND = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_HSPOS  = H_W'(H_ACTIVE + H_FRONT);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACTEND = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_VSPOS  = V_W'(V_ACTIVE + V_FRONT);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  logic [H_W-1:0]   h_cnt_q, h_cnt_d;
  logic [V_W-1:0]   v_cnt_q, v_cnt_d;
  logic [SUB_W-1:0] x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [COL_W-1:0] x_pix_q, x_pix_d;
  logic [ROW_W-1:0] y_pix_q, y_pix_d;
  logic             h_wrap_s, v_wrap_s, h_act_s, v_act_s;

  assign h_wrap_s = (h_cnt_q == H_LAST);
  assign v_wrap_s = (v_cnt_q == V_LAST);
  assign h_act_s  = (h_cnt_q < H_ACTEND);
  assign v_act_s  = (v_cnt_q < V_ACTEND);

  // Next-state for raster and pixel counters.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    x_sub_d = x_sub_q;
    x_pix_d = x_pix_q;
    y_sub_d = y_sub_q;
    y_pix_d = y_pix_q;

    // Horizontal: x only advances inside the active part of the line, so it
    // simply parks during blanking until the line wrap clears it.
    if (h_wrap_s) begin
      h_cnt_d = '0;
      x_sub_d = '0;
      x_pix_d = '0;
    end else begin
      h_cnt_d = h_cnt_q + H_W'(1);
      if (h_act_s) begin
        if (x_sub_q == SUB_LAST) begin
          x_sub_d = '0;
          x_pix_d = x_pix_q + COL_W'(1);
        end else begin
          x_sub_d = x_sub_q + SUB_W'(1);
        end
      end else begin
        x_sub_d = x_sub_q;
      end
    end

    // Vertical: same scheme, stepped once per line wrap.
    if (h_wrap_s) begin
      if (v_wrap_s) begin
        v_cnt_d = '0;
        y_sub_d = '0;
        y_pix_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + V_W'(1);
        if (v_act_s) begin
          if (y_sub_q == SUB_LAST) begin
            y_sub_d = '0;
            y_pix_d = y_pix_q + ROW_W'(1);
          end else begin
            y_sub_d = y_sub_q + SUB_W'(1);
          end
        end else begin
          y_sub_d = y_sub_q;
        end
      end
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_sub_q <= '0;
      x_pix_q <= '0;
      y_sub_q <= '0;
      y_pix_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_sub_q <= x_sub_d;
      x_pix_q <= x_pix_d;
      y_sub_q <= y_sub_d;
      y_pix_q <= y_pix_d;
    end
  end

  assign active_o      = h_act_s & v_act_s;
  assign hs_o          = (h_cnt_q == H_HSPOS);
  assign vs_o          = (v_cnt_q == V_VSPOS) && (h_cnt_q == '0);
  assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign x_pix_o       = x_pix_q;
  assign y_pix_o       = y_pix_q;

endmodule

// File: rtl/synch_2.sv
// -----------------------------------------------------------------------------
// synch_2
// Two-flop synchroniser for quasi-static control bits crossing into clk.
// Ports: clk / rst_n (async active-low), in_i (async), out_o (synchronised).
// -----------------------------------------------------------------------------
module synch_2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage resynchronisation register chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
    end
  end

  assign out_o = sync_q;

endmodule

// File: rtl/oled_video_scanout.sv
// -----------------------------------------------------------------------------
// oled_video_scanout
// Reads the 128x64 page-organised OLED framebuffer and produces scaled video.
// Pipeline (3 clocks from counter state to outputs, all outputs aligned):
//   S1 read_addr + tag registered, S2 memory returns byte / tag delayed,
//   S3 bit select, inversion and colour mux registered onto the outputs.
// Ports: clk_video, reset_n (async active-low), invert_video (async)
//        read_addr / read_data  framebuffer byte port (1-clock read latency)
//        video_rgb / video_de / video_hs / video_vs  video output
// -----------------------------------------------------------------------------
module oled_video_scanout
  import oled_pkg::*;
#(
  parameter int          SCALE    = 3,
  parameter int          H_FRONT  = 16,
  parameter int          H_SYNC   = 8,
  parameter int          H_BACK   = 32,
  parameter int          V_FRONT  = 4,
  parameter int          V_SYNC   = 2,
  parameter int          V_BACK   = 10,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic                 clk_video,
  input  logic                 reset_n,
  input  logic                 invert_video,
  output logic [FB_ADDR_W-1:0] read_addr,
  input  logic [7:0]           read_data,
  output logic [23:0]          video_rgb,
  output logic                 video_de,
  output logic                 video_hs,
  output logic                 video_vs
);

  logic             active_s, hs_s, vs_s, frame_start_s, invert_sync_s, pixel_s;
  logic [COL_W-1:0] x_pix_s;
  logic [ROW_W-1:0] y_pix_s;
  fb_addr_t         addr_q, addr_d;
  scan_tag_t        s1_q, s1_d, s2_q;
  logic             invert_frame_q, invert_frame_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             de_q, hs_q, vs_q;

  oled_video_timing #(
    .SCALE  (SCALE),
    .H_FRONT(H_FRONT),
    .H_SYNC (H_SYNC),
    .H_BACK (H_BACK),
    .V_FRONT(V_FRONT),
    .V_SYNC (V_SYNC),
    .V_BACK (V_BACK)
  ) u_timing (
    .clk_i        (clk_video),
    .rst_ni       (reset_n),
    .active_o     (active_s),
    .hs_o         (hs_s),
    .vs_o         (vs_s),
    .frame_start_o(frame_start_s),
    .x_pix_o      (x_pix_s),
    .y_pix_o      (y_pix_s)
  );

  synch_2 #(.WIDTH(1)) u_invert_sync (
    .clk  (clk_video),
    .rst_n(reset_n),
    .in_i (invert_video),
    .out_o(invert_sync_s)
  );

  // SSD1306 bit order: LSB of a page byte is the top row of that page.
  assign pixel_s = read_data[s2_q.bit_idx] ^ invert_frame_q;

  // Next-state for address stage, inversion latch and colour mux.
  always_comb begin
    addr_d         = '0;
    s1_d           = '0;
    invert_frame_d = invert_frame_q;
    rgb_d          = '0;

    if (active_s) begin
      addr_d = fb_addr(page_t'(y_pix_s[5:3]), x_pix_s);
    end else begin
      addr_d = '0;
    end
    s1_d.active  = active_s;
    s1_d.hs      = hs_s;
    s1_d.vs      = vs_s;
    s1_d.bit_idx = y_pix_s[2:0];

    // Inversion only changes at the top-left corner so a frame never tears.
    if (frame_start_s) begin
      invert_frame_d = invert_sync_s;
    end else begin
      invert_frame_d = invert_frame_q;
    end

    if (s2_q.active) begin
      rgb_d = pixel_s ? FG_COLOR : BG_COLOR;
    end else begin
      rgb_d = '0;
    end
  end

  // Pipeline registers S1..S3 and the frame inversion latch.
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      addr_q         <= '0;
      s1_q           <= '0;
      s2_q           <= '0;
      invert_frame_q <= 1'b0;
      rgb_q          <= '0;
      de_q           <= 1'b0;
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      s1_q           <= s1_d;
      s2_q           <= s1_q;
      invert_frame_q <= invert_frame_d;
      rgb_q          <= rgb_d;
      de_q           <= s2_q.active;
      hs_q           <= s2_q.hs;
      vs_q           <= s2_q.vs;
    end
  end

  assign read_addr = addr_q;
  assign video_rgb = rgb_q;
  assign video_de  = de_q;
  assign video_hs  = hs_q;
  assign video_vs  = vs_q;

endmodule

// File: tb/tb_oled_video_scanout.sv
// -----------------------------------------------------------------------------
// tb_oled_video_scanout
// Built with SCALE=2 and short porches so that two complete frames plus a
// mid-frame reset fit in a short run. The reference model maps elapsed clocks
// since reset release straight to a raster position with plain division.
// -----------------------------------------------------------------------------
module tb_oled_video_scanout;

  localparam int S   = 2;
  localparam int HF  = 6;
  localparam int HSY = 4;
  localparam int HB  = 10;
  localparam int VF  = 3;
  localparam int VSY = 2;
  localparam int VB  = 3;
  localparam int HA  = 128 * S;
  localparam int VA  = 64 * S;
  localparam int HT  = HA + HF + HSY + HB;
  localparam int VT  = VA + VF + VSY + VB;
  localparam int FR  = HT * VT;
  localparam logic [23:0] FG = 24'hF0A050;
  localparam logic [23:0] BG = 24'h102030;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        invert_video;
  logic [9:0]  read_addr;
  logic [7:0]  read_data = 8'h00;
  logic [23:0] video_rgb;
  logic        video_de, video_hs, video_vs;

  logic [7:0]  mem [0:1023];
  bit          inv_frame [0:3];
  int          t;
  int          n_vec;
  int          n_err;

  always #5 clk = ~clk;

  // Synchronous framebuffer read port, one clock of latency.
  always @(posedge clk) read_data <= mem[read_addr];

  oled_video_scanout #(
    .SCALE   (S),
    .H_FRONT (HF),
    .H_SYNC  (HSY),
    .H_BACK  (HB),
    .V_FRONT (VF),
    .V_SYNC  (VSY),
    .V_BACK  (VB),
    .FG_COLOR(FG),
    .BG_COLOR(BG)
  ) dut (
    .clk_video   (clk),
    .reset_n     (reset_n),
    .invert_video(invert_video),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .video_rgb   (video_rgb),
    .video_de    (video_de),
    .video_hs    (video_hs),
    .video_vs    (video_vs)
  );

  // Expected {read_addr, rgb, de, hs, vs} observed after the tt-th edge.
  function automatic logic [36:0] model(input int tt);
    int pa, po, r, v, h, f, row, col;
    logic [9:0]  ea;
    logic [23:0] er;
    logic        ed, eh, ev;
    logic [7:0]  byte_v;
    ea = '0; er = '0; ed = 1'b0; eh = 1'b0; ev = 1'b0;
    pa = tt - 1;
    po = tt - 3;
    if (pa >= 0) begin
      r = pa % FR; v = r / HT; h = r % HT;
      if (h < HA && v < VA) ea = 10'(((v / S) / 8) * 128 + h / S);
    end
    if (po >= 0) begin
      f = po / FR; r = po % FR; v = r / HT; h = r % HT;
      ed = (h < HA) && (v < VA);
      eh = (h == HA + HF);
      ev = (v == VA + VF) && (h == 0);
      if (ed) begin
        row = v / S; col = h / S;
        byte_v = mem[(row / 8) * 128 + col];
        er = (byte_v[row % 8] ^ inv_frame[f]) ? FG : BG;
      end
    end
    return {ea, er, ed, eh, ev};
  endfunction

  task automatic step();
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0]    = 8'h01;
    mem[1023] = 8'h80;
  endtask

  task automatic test_reset();
    logic [36:0] got;
    reset_n = 1'b0;
    invert_video = 1'b0;
    fill_random();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = {read_addr, video_rgb, video_de, video_hs, video_vs};
      n_vec++;
      if (got !== 37'd0) begin
        n_err++;
        $display("FAIL reset_state cyc=%0d got %h expected %h", i, got, 37'd0);
      end
    end
    reset_n = 1'b1;
    t = 0;
    for (int i = 0; i < 4; i++) inv_frame[i] = 1'b0;
  endtask

  // Frame 0: random image, sync/DE counting, invert raised mid-frame.
  task automatic test_frame_timing();
    logic [36:0] got, exp;
    int po, r, v, h;
    int hs_cnt = 0, vs_cnt = 0, de_run = 0, de_lines = 0, last_hs = -1;
    for (int k = 0; k < FR; k++) begin
      step();
      exp = model(t);
      got = {read_addr, video_rgb, video_de, video_hs, video_vs};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL frame0 t=%0d got %h expected %h", t, got, exp);
      end
      if (video_hs) begin
        if (last_hs >= 0) begin
          n_vec++;
          if (t - last_hs !== HT) begin
            n_err++;
            $display("FAIL hs_period t=%0d got %0d expected %0d", t, t - last_hs, HT);
          end
        end
        last_hs = t;
        hs_cnt++;
      end
      if (video_vs) vs_cnt++;
      if (video_de) de_run++;
      else if (de_run > 0) begin
        n_vec++;
        if (de_run !== HA) begin
          n_err++;
          $display("FAIL de_width t=%0d got %0d expected %0d", t, de_run, HA);
        end
        de_lines++;
        de_run = 0;
      end
      po = t - 3;
      if (po >= 0) begin
        r = po % FR; v = r / HT; h = r % HT;
        if (v == 100 && h == 0) begin
          invert_video = 1'b1;
          inv_frame[1] = 1'b1;
          inv_frame[2] = 1'b1;
        end
        if (v == VA + 1 && h == 0) begin
          for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        end
      end
    end
    n_vec++;
    if (hs_cnt !== VT) begin
      n_err++;
      $display("FAIL hs_count got %0d expected %0d", hs_cnt, VT);
    end
    n_vec++;
    if (vs_cnt !== 1) begin
      n_err++;
      $display("FAIL vs_count got %0d expected 1", vs_cnt);
    end
    n_vec++;
    if (de_lines !== VA) begin
      n_err++;
      $display("FAIL de_lines got %0d expected %0d", de_lines, VA);
    end
  endtask

  // Frame 1: blank memory with inversion latched shows FG everywhere.
  task automatic test_invert_frame();
    logic [36:0] got, exp;
    int fg_px = 0, other_px = 0;
    for (int k = 0; k < FR; k++) begin
      step();
      exp = model(t);
      got = {read_addr, video_rgb, video_de, video_hs, video_vs};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL invert_frame t=%0d got %h expected %h", t, got, exp);
      end
      if (video_de && video_rgb == FG) fg_px++;
      if (video_de && video_rgb != FG) other_px++;
    end
    n_vec++;
    if (fg_px !== HA * VA || other_px !== 0) begin
      n_err++;
      $display("FAIL invert_fg_count got %0d/%0d expected %0d/0", fg_px, other_px, HA * VA);
    end
  endtask

  // Frame 2: asynchronous reset partway through, then a clean restart.
  task automatic test_midframe_reset();
    logic [36:0] got, exp;
    int first_de = -1;
    while (t < 2 * FR + 10 * HT + 200 + 3) begin
      step();
      exp = model(t);
      got = {read_addr, video_rgb, video_de, video_hs, video_vs};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL pre_reset t=%0d got %h expected %h", t, got, exp);
      end
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    got = {read_addr, video_rgb, video_de, video_hs, video_vs};
    n_vec++;
    if (got !== 37'd0) begin
      n_err++;
      $display("FAIL async_reset got %h expected %h", got, 37'd0);
    end
    fill_random();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {read_addr, video_rgb, video_de, video_hs, video_vs};
      n_vec++;
      if (got !== 37'd0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got %h expected %h", i, got, 37'd0);
      end
    end
    reset_n = 1'b1;
    t = 0;
    for (int i = 0; i < 4; i++) inv_frame[i] = 1'b0;
    for (int k = 0; k < 3 * HT + 10; k++) begin
      step();
      exp = model(t);
      got = {read_addr, video_rgb, video_de, video_hs, video_vs};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL restart t=%0d got %h expected %h", t, got, exp);
      end
      if (video_de && first_de < 0) first_de = t;
    end
    n_vec++;
    if (first_de !== 3) begin
      n_err++;
      $display("FAIL first_de_latency got %0d expected 3", first_de);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    t = 0;
    test_reset();
    test_frame_timing();
    test_invert_frame();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oled_video_scanout.md
Name: oled_video_scanout

Overview:
- Downstream consumer of the SSD1306 OLED framebuffer.
- Generates Pocket-style video timing and walks the 128x64 1bpp page-organised framebuffer through its byte read port.
- Scales each OLED pixel by SCALE in both axes and applies display inversion at frame boundaries.
- Drives 24-bit RGB plus DE/HS/VS to the Pocket video output.

Parameters:
- SCALE, 3: integer pixel replication factor; active area is 128*SCALE x 64*SCALE.
- H_FRONT, 16: horizontal front porch, in clocks.
- H_SYNC, 8: clocks from front-porch end to back-porch start; HS pulses on the first of these.
- H_BACK, 32: horizontal back porch, in clocks.
- V_FRONT, 4: vertical front porch, in lines.
- V_SYNC, 2: lines from front-porch end to back-porch start; VS pulses at the start of the first.
- V_BACK, 10: vertical back porch, in lines.
- FG_COLOR, 24'hFFFFFF: RGB for a lit pixel.
- BG_COLOR, 24'h000000: RGB for an unlit pixel in the active area.

Ports:
- clk_video  in  1  pixel clock; the framebuffer read port (clk_read_mem) is driven by this same clock.
- reset_n  in  1  asynchronous, active-low reset.
- invert_video  in  1  inversion flag from the OLED SPI domain (asynchronous).
- read_addr  out  10  framebuffer byte address {page[2:0], column[6:0]}.
- read_data  in  8  framebuffer byte, valid one clock after read_addr.
- video_rgb  out  24  pixel colour.
- video_de  out  1  active-area data enable.
- video_hs  out  1  one-clock horizontal sync pulse.
- video_vs  out  1  one-clock vertical sync pulse.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - h_cnt, v_cnt, sub-pixel counters, read_addr, video_rgb, video_de, video_hs, video_vs all go to 0.
  - Latched invert goes to 0; pipeline is flushed.
  - After release, the scan restarts at h=0, v=0 (first active pixel).
- Timing geometry:
  - H_ACTIVE = 128*SCALE, H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (440 with defaults).
  - V_ACTIVE = 64*SCALE, V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (208 with defaults).
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments on the h_cnt wrap, counts 0..V_TOTAL-1 and wraps to 0.
- Active area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; pixels come first in each line and frame, blanking follows.
- Pixel coordinates, with no division or multiplication:
  - x_sub counts 0..SCALE-1. On wrap, x_pix increments over 0..127.
  - Both x_sub and x_pix reset to 0 at h_cnt wrap.
  - y_sub and y_pix behave the same way, advancing on line wrap, and reset to 0 at v_cnt wrap.
- Sync pulses:
  - HS is asserted when h_cnt == H_ACTIVE+H_FRONT.
  - VS is asserted when v_cnt == V_ACTIVE+V_FRONT and h_cnt == 0.
- Pipeline (fixed 3-clock latency from counter state to outputs; DE, HS, VS and RGB stay aligned):
  - S1 (registered): read_addr = {y_pix[5:3], x_pix}, or 0 outside the active area. Bit index y_pix[2:0] and the active/HS/VS flags are registered alongside.
  - S2: memory returns read_data; the S1 flags are delayed one stage.
  - S3 (registered output): pixel = read_data[bit_idx] ^ invert_frame. The bit is LSB = top row of the page, per SSD1306.
  - S3 RGB: video_rgb = pixel ? FG_COLOR : BG_COLOR when active, otherwise 0.
- Inversion:
  - invert_video passes through synch_2 (WIDTH 1).
  - The synced value is latched into invert_frame only when h_cnt == 0 and v_cnt == 0, so changes never tear mid-frame.
- Framebuffer writes during scan are permitted. Tearing from concurrent writes is acceptable and not masked.
- Pixel geometry: each OLED pixel occupies exactly SCALE x SCALE output clocks/lines. Column 127 ends at h_cnt = H_ACTIVE-1 and row 63 ends at v_cnt = V_ACTIVE-1.

Decomposition:
- Shared package oled_pkg:
  - OLED_WIDTH = 128, OLED_HEIGHT = 64, OLED_PAGES = 8.
  - FB_ADDR_W = 10.
  - Page/column field widths (3/7).
  - These are shared with the SPI framebuffer writer.
- Sub-module oled_video_timing:
  - Contains the h/v counters, sub-pixel/pixel counters, active flag and sync strobes.
  - The top level keeps the address/data pipeline, inversion latch and colour mux.
- synch_2 is reused as-is.

Test Plan:
- Reset, then free-run one frame with defaults:
  - video_hs pulses 208 times, one clock each, 440 clocks apart.
  - video_vs pulses exactly once.
  - video_de is high for exactly 384 clocks on each of 192 lines.
- Framebuffer model with byte 0x01 at addr 0, all others 0:
  - Output rows 0-2, clocks 0-2 of each line are FG_COLOR; every other active pixel is BG_COLOR.
  - The first FG pixel appears 3 clocks after h=0, v=0.
- Byte 0x80 at addr {3'd7, 7'd127}:
  - FG_COLOR appears on lines 189-191, active clocks 381-383 only, with read_addr = 0x3FF during those lines.
- invert_video toggled 1 mid-frame (v=100):
  - The current frame is unchanged.
  - The next frame shows all-zero memory as FG_COLOR on all 73728 active pixels.
- reset_n asserted at v=50, h=200:
  - All outputs go to 0 immediately.
  - After release, the first DE assertion is 3 clocks later with read_addr sequence 0,0,0,1.
- SCALE=1 build:
  - DE width is 128 and active lines are 64.
  - read_addr increments every clock across a line.
